// File: rtl/uart_frame_check.sv
// uart_frame_check
//   Validates fixed-length frames captured by a UART receiver. A frame is
//   latched on sync. Its 32-bit header is then compared against MSGID. An
//   8-bit XOR checksum is then accumulated one byte per cycle over bytes
//   0..N-2 and compared with byte N-1. Good frames publish their payload.
//   The block also keeps good/error counters and a link-alive indicator.
//
// Parameters
//   BUFFER_SIZE   frame width in bits (multiple of 8, >= 48)
//   MSGID         expected header in rx_data[BUFFER_SIZE-1 -: 32]
//   TimeoutCycles cycles without a good frame before link_ok drops
//   CountWidth    internal counter width (16 normally; smaller for debug builds)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_data      received frame, byte 0 in the top 8 bits
//   sync         one-cycle strobe, rx_data valid in the same cycle
//   frame_data   payload (bytes 4..N-2) of the last good frame
//   frame_valid  one-cycle pulse, frame_data updated
//   frame_error  one-cycle pulse, frame rejected
//   link_ok      good frames are arriving within TimeoutCycles
//   good_count   good frames, saturating
//   err_count    rejected frames plus overruns, saturating

module uart_frame_check #(
   parameter int unsigned BUFFER_SIZE   = 80,
   parameter logic [31:0] MSGID         = 32'h74697277,
   parameter int unsigned TimeoutCycles = 1200000,
   parameter int unsigned CountWidth    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [BUFFER_SIZE-1:0]  rx_data,
   input  logic                    sync,
   output logic [BUFFER_SIZE-41:0] frame_data,
   output logic                    frame_valid,
   output logic                    frame_error,
   output logic                    link_ok,
   output logic [15:0]             good_count,
   output logic [15:0]             err_count
);

   localparam int unsigned NBYTES = BUFFER_SIZE / 8;
   localparam int unsigned IDX_W  = $clog2(NBYTES);
   localparam int unsigned TO_W   = $clog2(TimeoutCycles + 1);

   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NBYTES - 2);
   localparam logic [TO_W-1:0]       TO_MAX   = TO_W'(TimeoutCycles);
   localparam logic [CountWidth-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE,
      IDCHK,
      SUM
   } state_t;

   state_t                  state_q, state_d;
   logic [BUFFER_SIZE-1:0]  shadow_q;
   logic [7:0]              acc_q;
   logic [IDX_W-1:0]        idx_q;
   logic                    chk_pend_q;
   logic [CountWidth-1:0]   good_q, err_q;
   logic [TO_W-1:0]         tcnt_q, tcnt_d;

   logic                    accept, overrun, id_bad, sum_last, sum_match;
   logic                    fv_d, fe_d;
   logic [1:0]              good_inc, err_inc;
   logic [BUFFER_SIZE-1:0]  shifted;
   logic [7:0]              cur_byte;

   function automatic logic [CountWidth-1:0] sat_add(
      input logic [CountWidth-1:0] cnt,
      input logic [1:0]            inc
   );
      logic [CountWidth:0] s;
      s = {1'b0, cnt} + (CountWidth + 1)'(inc);
      return s[CountWidth] ? CNT_MAX : s[CountWidth-1:0];
   endfunction

   // Byte idx_q of the shadow frame, counted from the top.
   always_comb begin
      shifted  = shadow_q << {idx_q, 3'b000};
      cur_byte = shifted[BUFFER_SIZE-1 -: 8];
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      overrun  = 1'b0;
      id_bad   = 1'b0;
      sum_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync) begin
               accept  = 1'b1;
               state_d = IDCHK;
            end
         end
         IDCHK: begin
            overrun = sync;
            if (shadow_q[BUFFER_SIZE-1 -: 32] != MSGID) begin
               id_bad  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = SUM;
            end
         end
         SUM: begin
            overrun = sync;
            if (idx_q == LAST_IDX) begin
               sum_last = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // The checksum verdict is taken in the cycle after the last SUM beat,
      // once acc_q already includes byte N-2. shadow_q is still intact then:
      // a sync accepted in that same cycle only overwrites it at the edge.
      sum_match = (acc_q == shadow_q[7:0]);
      fv_d      = chk_pend_q & sum_match;
      fe_d      = id_bad | (chk_pend_q & ~sum_match);
      good_inc  = {1'b0, fv_d};
      err_inc   = {1'b0, fe_d} + {1'b0, overrun};

      if (fv_d) begin
         tcnt_d = '0;
      end else if (tcnt_q != TO_MAX) begin
         tcnt_d = tcnt_q + 1'b1;
      end else begin
         tcnt_d = tcnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shadow_q    <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         chk_pend_q  <= 1'b0;
         frame_data  <= '0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         link_ok     <= 1'b0;
         good_q      <= '0;
         err_q       <= '0;
         tcnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         chk_pend_q <= sum_last;

         if (accept) begin
            shadow_q <= rx_data;
            acc_q    <= '0;
         end else if (state_q == SUM) begin
            acc_q    <= acc_q ^ cur_byte;
         end

         if (state_q == IDCHK) begin
            idx_q <= '0;
         end else if (state_q == SUM) begin
            idx_q <= idx_q + 1'b1;
         end

         frame_valid <= fv_d;
         frame_error <= fe_d;
         if (fv_d) begin
            frame_data <= shadow_q[BUFFER_SIZE-33:8];
         end

         good_q <= sat_add(good_q, good_inc);
         err_q  <= sat_add(err_q, err_inc);

         // link_ok drops on the same edge the counter reaches the limit.
         tcnt_q  <= tcnt_d;
         link_ok <= fv_d | (link_ok & (tcnt_d != TO_MAX));
      end
   end

   assign good_count = 16'(good_q);
   assign err_count  = 16'(err_q);

endmodule
